// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity constants and frame state encoding
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Frame phases; the receiver walks the same sequence.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-time counter, ticks on the last clk of each bit
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == TERM);

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with ready/busy/done handshake
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] tx,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 out
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state, state_next;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 par_bit, par_next;
  logic                 tick;
  logic                 baud_clear;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      par_bit <= par_next;
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    par_next     = par_bit;
    out          = 1'b1;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (send) begin
          shreg_next   = tx;
          par_next     = (PARITY == PARITY_EVEN) ? ^tx : ~^tx;
          bit_cnt_next = '0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        out = 1'b0;
        if (tick) begin
          bit_cnt_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        out = shreg[0];
        if (tick) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        out = par_bit;
        if (tick) begin
          bit_cnt_next = '0;
          state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        // bit_cnt is reused to count stop bits
        if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            done         = 1'b1;
            bit_cnt_next = '0;
            state_next   = ST_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // The counter is held in IDLE and restarted on every phase change.
  assign baud_clear = (state == ST_IDLE) || (state_next != state);
  assign ready      = (state == ST_IDLE);
  assign busy       = ~ready;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param across four frame formats
module tb_uart_tx_param;

  localparam int NI  = 4;
  localparam int CPB = 4;

  function automatic int db_of(int g);  return (g == 3) ? 7 : 8; endfunction
  function automatic int par_of(int g); return (g == 1) ? 2 : ((g == 2) ? 1 : 0); endfunction
  function automatic int sb_of(int g);  return (g == 3) ? 2 : 1; endfunction
  function automatic int flen(int g);
    return CPB * (1 + db_of(g) + ((par_of(g) != 0) ? 1 : 0) + sb_of(g));
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send_v [NI];
  logic [8:0] tx_v   [NI];
  logic       out_v  [NI];
  logic       ready_v[NI];
  logic       busy_v [NI];
  logic       done_v [NI];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   pos[NI];
  logic fr[NI][16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY      (par_of(g)),
      .STOP_BITS   (sb_of(g))
    ) u_dut (
      .clk  (clk),
      .rst  (rst),
      .send (send_v[g]),
      .tx   (tx_v[g][DB-1:0]),
      .ready(ready_v[g]),
      .busy (busy_v[g]),
      .done (done_v[g]),
      .out  (out_v[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: pos = cycles since accept (-1 when idle); frame = list of bit values.
  always @(posedge clk or posedge rst) begin
    for (int g = 0; g < NI; g++) begin
      if (rst) begin
        pos[g] = -1;
      end else if (pos[g] < 0) begin
        if (send_v[g] === 1'b1) begin
          int ones;
          int idx;
          ones = 0;
          for (int i = 0; i < 16; i++) fr[g][i] = 1'b1;
          fr[g][0] = 1'b0;
          for (int i = 0; i < db_of(g); i++) begin
            fr[g][1+i] = tx_v[g][i];
            if (tx_v[g][i] === 1'b1) ones++;
          end
          idx = 1 + db_of(g);
          if (par_of(g) == 2) fr[g][idx] = ((ones % 2) == 1);
          if (par_of(g) == 1) fr[g][idx] = ((ones % 2) == 0);
          pos[g] = 0;
        end
      end else if (pos[g] == flen(g) - 1) begin
        pos[g] = -1;
      end else begin
        pos[g] = pos[g] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("out[%0d]", g),   out_v[g],   (pos[g] < 0) ? 1'b1 : fr[g][pos[g] / CPB]);
      chk($sformatf("ready[%0d]", g), ready_v[g], (pos[g] < 0));
      chk($sformatf("busy[%0d]", g),  busy_v[g],  (pos[g] >= 0));
      chk($sformatf("done[%0d]", g),  done_v[g],  (pos[g] == flen(g) - 1));
    end
  end

  task automatic start(input int g, input logic [8:0] word);
    send_v[g] = 1'b1;
    tx_v[g]   = word;
  endtask

  // Called at the negedge just before the accepting posedge; returns cycles to done.
  task automatic watch(input int g, input bit drop, input int chg_at, input logic [8:0] chg_val,
                       output int dlen, output logic [15:0] bits);
    dlen = -1;
    bits = '0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (drop && k == 1) send_v[g] = 1'b0;
      if (k == chg_at) tx_v[g] = chg_val;
      if (((k - 1) % CPB) == 2 && ((k - 1) / CPB) < 16) bits[(k - 1) / CPB] = out_v[g];
      if (done_v[g] === 1'b1) begin
        dlen = k;
        break;
      end
    end
  endtask

  initial begin
    int          dlen;
    logic [15:0] bits;

    for (int g = 0; g < NI; g++) begin
      pos[g]    = -1;
      send_v[g] = 1'b1;
      tx_v[g]   = 9'h0;
    end

    // Reset with send asserted: must stay idle.
    repeat (3) @(negedge clk);
    chk("rst_out", out_v[0], 1'b1);
    chk("rst_ready", ready_v[0], 1'b1);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    for (int g = 0; g < NI; g++) send_v[g] = 1'b0;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_out", out_v[0], 1'b1);

    // 8N1, 0x67
    start(0, 9'h067);
    watch(0, 1'b1, 0, 9'h0, dlen, bits);
    chk("t1_len", dlen, 40);
    chk("t1_bits", bits[9:0], 10'h2CE);
    @(negedge clk);
    chk("t1_ready_after", ready_v[0], 1'b1);

    // Even parity
    start(1, 9'h067);
    watch(1, 1'b1, 0, 9'h0, dlen, bits);
    chk("t2e_len", dlen, 44);
    chk("t2e_data", bits[8:1], 8'h67);
    chk("t2e_parity", bits[9], 1'b1);
    @(negedge clk);

    // Odd parity
    start(2, 9'h067);
    watch(2, 1'b1, 0, 9'h0, dlen, bits);
    chk("t2o_len", dlen, 44);
    chk("t2o_parity", bits[9], 1'b0);
    chk("t2o_stop", bits[10], 1'b1);
    @(negedge clk);

    // 7 data bits, 2 stop bits
    start(3, 9'h041);
    watch(3, 1'b1, 0, 9'h0, dlen, bits);
    chk("t3_len", dlen, 40);
    chk("t3_start", bits[0], 1'b0);
    chk("t3_data", bits[7:1], 7'h41);
    chk("t3_stop", bits[9:8], 2'b11);
    @(negedge clk);

    // Back-to-back with send held, tx changed mid-frame
    start(0, 9'h067);
    watch(0, 1'b0, 20, 9'h0A5, dlen, bits);
    chk("t4_len1", dlen, 40);
    chk("t4_data1", bits[8:1], 8'h67);
    @(negedge clk);
    chk("t4_idle_ready", ready_v[0], 1'b1);
    watch(0, 1'b1, 0, 9'h0, dlen, bits);
    chk("t4_len2", dlen, 40);
    chk("t4_data2", bits[8:1], 8'hA5);
    @(negedge clk);

    // Reset during data bit 3
    start(0, 9'h067);
    @(negedge clk);
    send_v[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("t5_pre_out", out_v[0], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out", out_v[0], 1'b1);
    chk("t5_rst_ready", ready_v[0], 1'b1);
    chk("t5_rst_busy", busy_v[0], 1'b0);
    chk("t5_rst_done", done_v[0], 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start(0, 9'h067);
    watch(0, 1'b1, 0, 9'h0, dlen, bits);
    chk("t5_len", dlen, 40);
    chk("t5_bits", bits[9:0], 10'h2CE);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised successor to the fixed 8N1 UART transmitter.
- Serialises one word per `send` handshake onto `out`, LSB first.
- Frame format is set by parameters: data bits, parity (none/odd/even), 1 or 2 stop bits, clocks per bit.
- Adds ready/busy/done handshaking so a host FSM or FIFO can stream words back-to-back; sits between the byte source and the pad.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, payload width; legal range 5..9.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- send  input  1  request to transmit `tx`.
- tx  input  DATA_BITS  word to send; sampled only in the accept cycle.
- ready  output  1  high in IDLE; a word is accepted when send && ready.
- busy  output  1  high from the cycle after accept until the end of the last stop bit.
- done  output  1  one-cycle pulse in the final clk of the last stop bit.
- out  output  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release):
  - out=1, ready=1, busy=0, done=0.
  - State = IDLE; bit counter and baud counter = 0.
- FSM states: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE.
- IDLE:
  - out=1, ready=1.
  - On send=1: latch tx into the shift register and compute parity from the latched word.
  - Move to START next cycle.
- START: out=0 for CLKS_PER_BIT cycles.
- DATA:
  - out = shreg[0] for CLKS_PER_BIT cycles, then shift right.
  - Repeat DATA_BITS times; the bit counter runs 0..DATA_BITS-1 and does not wrap.
- PARITY:
  - Even: out = ^data. Odd: out = ~^data.
  - Lasts one bit time.
- STOP:
  - out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - done=1 in the final cycle; then IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1; the terminal count advances the bit or state.
  - Resets to 0 on every state entry.
- Latency: out falls exactly 1 cycle after the accept edge.
- Frame length (accept to done inclusive of last stop cycle): CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles after the accept cycle.
- Back-to-back with send held high:
  - Returns to IDLE for exactly one cycle (out=1, ready=1) and accepts the next word there.
  - Inter-frame gap is 1 clk plus the stop bits.
- send while busy: ignored, not queued.
- tx changes while busy: no effect on the frame in flight.
- done and ready are never high in the same cycle.
- busy == ~ready at all times outside reset.
- Reset mid-frame: out goes high immediately (async), frame is abandoned, no done pulse.
- Illegal parameters (PARITY>2, STOP_BITS not 1/2, CLKS_PER_BIT<2): elaboration-time error.

Decomposition:
- Shared package uart_pkg:
  - Parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - FSM state encoding, also reused by the planned RX.
- One sub-module: uart_baud_gen, parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick.
  - Shared with the future receiver.
- Shift register and FSM stay in uart_tx_param.

Test Plan:
1. Defaults with CLKS_PER_BIT=4, tx=8'h67, send pulsed 1 cycle:
   - out = 0,1,1,1,0,0,1,1,0,1, each bit held 4 cycles; out falls 1 cycle after accept.
   - done pulses at cycle 40 after accept; ready returns the cycle after.
2. PARITY=2, tx=8'h67 (five ones):
   - Parity bit = 1 between data bit 7 and the stop bit.
   - PARITY=1 gives 0. Frame is 44 cycles.
3. DATA_BITS=7, STOP_BITS=2, tx=7'h41:
   - Bits 1,0,0,0,0,0,1 after start, then 8 cycles of stop high.
   - done in the last stop cycle.
4. send held high, tx changed to 8'hA5 mid-frame:
   - First frame still carries 8'h67.
   - Exactly one IDLE cycle, then the second frame carries 8'hA5.
   - No accept happens while busy.
5. rst asserted during DATA bit 3:
   - out=1, ready=1, busy=0 in the same timestep; no done pulse.
   - A new send after release produces a clean full frame.
6. Reset values: out, ready, busy, done checked during reset.
   - Assert send during reset: no frame is produced.
